hazard_scoreboard: RTL and testbench

//  Parametrised hazard/forwarding unit for the 5-stage pipeline with a register scoreboard for the multi-cycle multiplier.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_mul_tracker.sv | 78 +++++++
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: forwarding mux selects and the
// multiplier tracker state encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mulState_e;

endpackage

// File: rtl/hazard_mul_tracker.sv
// Multiplier scoreboard: follows one multiply from issue in E until its
// product is written, holding the destination's pending bit meanwhile.
// Only one multiply can be in flight, so a new issue is accepted in IDLE only.
module hazard_mul_tracker
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RAW     = 5,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            mulIssue,
    input  logic [RAW-1:0]  mulDst,
    output logic [NREG-1:0] pending,
    output logic            mulBusy,
    output logic            mulProdV
);

    localparam int CNT_W = $clog2(MUL_LAT);

    mulState_e       state;
    mulState_e       stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [RAW-1:0]   dstReg;
    logic [RAW-1:0]   dstNext;
    logic [NREG-1:0]  pendingNext;

    // Register the FSM state, latency counter, tracked destination and bitmap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            dstReg  <= '0;
            pending <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            dstReg  <= dstNext;
            pending <= pendingNext;
        end
    end

    // Accept a multiply in IDLE, count down in BUSY, pulse when the product lands
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        dstNext     = dstReg;
        pendingNext = pending;
        mulProdV    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mulIssue) begin
                    stateNext            = ST_BUSY;
                    cntNext              = CNT_W'(MUL_LAT - 1);
                    dstNext              = mulDst;
                    pendingNext[mulDst]  = 1'b1;
                end
            end
            ST_BUSY: begin
                cntNext = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    mulProdV            = 1'b1;
                    stateNext           = ST_IDLE;
                    pendingNext[dstReg] = 1'b0;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
        pendingNext[0] = 1'b0;
    end

    assign mulBusy = (state == ST_BUSY);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the 5-stage pipeline: E/D forwarding selects,
// load-use / branch / scoreboard stalls and the multiplier structural stall.
// Optional saturating stall/flush counters are built when HAZARD_PERF_CNT_EN
// is defined.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int RAW     = 5,
    parameter int MUL_LAT = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_W  = 32
`endif
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [RAW-1:0] rs_d,
    input  logic [RAW-1:0] rt_d,
    input  logic [RAW-1:0] rs_e,
    input  logic [RAW-1:0] rt_e,
    input  logic [RAW-1:0] write_reg_e,
    input  logic [RAW-1:0] write_reg_m,
    input  logic [RAW-1:0] write_reg_w,
    input  logic           reg_write_e,
    input  logic           reg_write_m,
    input  logic           reg_write_w,
    input  logic           mem_to_reg_e,
    input  logic           mem_to_reg_m,
    input  logic           branch_d,
    input  logic           mul_issue_e,
    input  logic [RAW-1:0] mul_dst_e,
    output logic [1:0]     forward_ae,
    output logic [1:0]     forward_be,
    output logic           forward_ad,
    output logic           forward_bd,
    output logic           stall_f,
    output logic           stall_d,
    output logic           flush_e,
    output logic           stall_e,
    output logic           mul_busy,
    output logic           mul_prod_v
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    logic [NREG-1:0] pending;
    logic            lwStall;
    logic            brStall;
    logic            sbStall;
    logic            hazardStall;

    hazard_mul_tracker #(
        .NREG    (NREG),
        .RAW     (RAW),
        .MUL_LAT (MUL_LAT)
    ) mulTracker (
        .clk      (clk),
        .reset_n  (reset_n),
        .mulIssue (mul_issue_e),
        .mulDst   (mul_dst_e),
        .pending  (pending),
        .mulBusy  (mul_busy),
        .mulProdV (mul_prod_v)
    );

    // E-stage operand selects: M result is newer than W, so it wins
    always_comb begin
        forward_ae = FWD_RF;
        forward_be = FWD_RF;
        if (rs_e != '0 && rs_e == write_reg_m && reg_write_m)
            forward_ae = FWD_M;
        else if (rs_e != '0 && rs_e == write_reg_w && reg_write_w)
            forward_ae = FWD_W;
        if (rt_e != '0 && rt_e == write_reg_m && reg_write_m)
            forward_be = FWD_M;
        else if (rt_e != '0 && rt_e == write_reg_w && reg_write_w)
            forward_be = FWD_W;
    end

    // D-stage branch comparator takes the M result directly
    assign forward_ad = (rs_d != '0) && (rs_d == write_reg_m) && reg_write_m;
    assign forward_bd = (rt_d != '0) && (rt_d == write_reg_m) && reg_write_m;

    // Stall sources: load-use, unresolved branch operands, pending multiply
    always_comb begin
        lwStall = mem_to_reg_e && (write_reg_e != '0) &&
                  (rs_d == write_reg_e || rt_d == write_reg_e);
        brStall = branch_d &&
                  ((reg_write_e && write_reg_e != '0 &&
                    (rs_d == write_reg_e || rt_d == write_reg_e)) ||
                   (mem_to_reg_m && write_reg_m != '0 &&
                    (rs_d == write_reg_m || rt_d == write_reg_m)));
        sbStall = pending[rs_d] || pending[rt_d];
        hazardStall = lwStall || brStall || sbStall;
    end

    // A waiting second multiply freezes E, so the front end holds without a bubble
    assign stall_e = mul_issue_e && mul_busy;
    assign stall_f = stall_e || hazardStall;
    assign stall_d = stall_e || hazardStall;
    assign flush_e = hazardStall && !stall_e;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating counts of stalled and flushed cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_e && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus a
// randomized run against a reference model that tracks the multiply by its
// issue cycle. Counter checks are built when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

    localparam int NREG    = 32;
    localparam int RAW     = 5;
    localparam int MUL_LAT = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam int PERF_W  = 4;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [RAW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [RAW-1:0] write_reg_e, write_reg_m, write_reg_w;
    logic           reg_write_e, reg_write_m, reg_write_w;
    logic           mem_to_reg_e, mem_to_reg_m, branch_d, mul_issue_e;
    logic [RAW-1:0] mul_dst_e;
    logic [1:0]     forward_ae, forward_be;
    logic           forward_ad, forward_bd;
    logic           stall_f, stall_d, flush_e, stall_e, mul_busy, mul_prod_v;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int issueCyc    = -1000;
    int issueDst    = 0;

    hazard_scoreboard #(
        .NREG    (NREG),
        .RAW     (RAW),
        .MUL_LAT (MUL_LAT)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .PERF_W  (PERF_W)
`endif
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .branch_d     (branch_d),
        .mul_issue_e  (mul_issue_e),
        .mul_dst_e    (mul_dst_e),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .stall_e      (stall_e),
        .mul_busy     (mul_busy),
        .mul_prod_v   (mul_prod_v)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: a multiply issued in cycle c occupies cycles c+1 .. c+MUL_LAT-1
    function automatic bit modelBusy(int c);
        return (c > issueCyc) && (c < issueCyc + MUL_LAT);
    endfunction

    function automatic bit modelProdV(int c);
        return modelBusy(c) && (c == issueCyc + MUL_LAT - 1);
    endfunction

    function automatic int modelPendingDst(int c);
        return modelBusy(c) ? issueDst : 0;
    endfunction

    // Expected output vector {fa,fb,ad,bd,sf,sd,fe,se,busy,pv} from the rules
    function automatic logic [11:0] modelOutputs(int c);
        logic [1:0] fa, fb;
        bit ad, bd, lw, br, sb, se, hz;
        int pd;
        fa = 2'b00;
        fb = 2'b00;
        if (rs_e != 0 && rs_e == write_reg_m && reg_write_m) fa = 2'b10;
        else if (rs_e != 0 && rs_e == write_reg_w && reg_write_w) fa = 2'b01;
        if (rt_e != 0 && rt_e == write_reg_m && reg_write_m) fb = 2'b10;
        else if (rt_e != 0 && rt_e == write_reg_w && reg_write_w) fb = 2'b01;
        ad = (rs_d != 0) && (rs_d == write_reg_m) && reg_write_m;
        bd = (rt_d != 0) && (rt_d == write_reg_m) && reg_write_m;
        lw = mem_to_reg_e && write_reg_e != 0 && (rs_d == write_reg_e || rt_d == write_reg_e);
        br = branch_d && ((reg_write_e && write_reg_e != 0 && (rs_d == write_reg_e || rt_d == write_reg_e)) ||
                          (mem_to_reg_m && write_reg_m != 0 && (rs_d == write_reg_m || rt_d == write_reg_m)));
        pd = modelPendingDst(c);
        sb = pd != 0 && (int'(rs_d) == pd || int'(rt_d) == pd);
        se = mul_issue_e && modelBusy(c);
        hz = lw || br || sb;
        return {fa, fb, ad, bd, se || hz, se || hz, hz && !se, se, modelBusy(c), modelProdV(c)};
    endfunction

    task automatic clearInputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0; branch_d = 1'b0;
        mul_issue_e = 1'b0; mul_dst_e = '0;
    endtask

    // Advance one clock, updating the model's view of an accepted multiply
    task automatic tick();
        bit accept;
        int dst;
        accept = reset_n && mul_issue_e && !modelBusy(cyc);
        dst = int'(mul_dst_e);
        @(posedge clk);
        if (accept) begin
            issueCyc = cyc;
            issueDst = dst;
        end
        cyc++;
        if (!reset_n) issueCyc = -1000;
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        reset_n = 1'b0;
        #2;
        testsRun++;
        if ({forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d, flush_e,
             stall_e, mul_busy, mul_prod_v} !== 12'h000) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got %h want 000",
                     {forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d,
                      flush_e, stall_e, mul_busy, mul_prod_v});
        end
`ifdef HAZARD_PERF_CNT_EN
        testsRun++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
`endif
        tick();
        tick();
        reset_n = 1'b1;
        issueCyc = -1000;
        #1;
    endtask

    task automatic test_forwarding();
        clearInputs();
        rs_e = 5'd3; rt_e = 5'd3; rs_d = 5'd3;
        write_reg_m = 5'd3; reg_write_m = 1'b1;
        write_reg_w = 5'd3; reg_write_w = 1'b1;
        #1;
        testsRun++;
        if (forward_ae !== 2'b10 || forward_be !== 2'b10 || forward_ad !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fwd_m_priority: got ae=%b be=%b ad=%b want 10 10 1",
                     forward_ae, forward_be, forward_ad);
        end
        reg_write_m = 1'b0;
        #1;
        testsRun++;
        if (forward_ae !== 2'b01 || forward_ad !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fwd_w: got ae=%b ad=%b want 01 0", forward_ae, forward_ad);
        end
        rs_e = 5'd0; write_reg_w = 5'd0;
        #1;
        testsRun++;
        if (forward_ae !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL fwd_r0: got ae=%b want 00", forward_ae);
        end
        tick();
    endtask

    task automatic test_load_stall();
        clearInputs();
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
        #1;
        testsRun++;
        if ({stall_f, stall_d, flush_e} !== 3'b111) begin
            testsFailed++;
            $display("[TB] FAIL load_use_stall: got %b want 111", {stall_f, stall_d, flush_e});
        end
        tick();
        clearInputs();
        mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd5; rt_e = 5'd5;
        #1;
        testsRun++;
        if ({stall_f, stall_d, flush_e} !== 3'b000 || forward_be !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL load_forward: got stalls=%b be=%b want 000 10",
                     {stall_f, stall_d, flush_e}, forward_be);
        end
        tick();
    endtask

    task automatic test_mul_stall();
        clearInputs();
        mul_issue_e = 1'b1; mul_dst_e = 5'd7;
        tick();
        for (int i = 0; i < MUL_LAT; i++) begin
            clearInputs();
            rs_d = 5'd7;
            #1;
            testsRun++;
            if (i < MUL_LAT - 1) begin
                if ({stall_f, stall_d, flush_e, mul_busy, mul_prod_v} !== {4'b1111, (i == MUL_LAT - 2)}) begin
                    testsFailed++;
                    $display("[TB] FAIL mul_dep_stall[%0d]: got %b want %b", i,
                             {stall_f, stall_d, flush_e, mul_busy, mul_prod_v},
                             {4'b1111, (i == MUL_LAT - 2)});
                end
            end else begin
                if ({stall_f, stall_d, flush_e, mul_busy, mul_prod_v} !== 5'b00000) begin
                    testsFailed++;
                    $display("[TB] FAIL mul_dep_release: got %b want 00000",
                             {stall_f, stall_d, flush_e, mul_busy, mul_prod_v});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        clearInputs();
        mul_issue_e = 1'b1; mul_dst_e = 5'd9;
        tick();
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_issue_e = 1'b1; mul_dst_e = 5'd10; rs_d = 5'd9;
            #1;
            testsRun++;
            if ({stall_f, stall_d, flush_e, stall_e} !== 4'b1101) begin
                testsFailed++;
                $display("[TB] FAIL b2b_wait[%0d]: got %b want 1101", i,
                         {stall_f, stall_d, flush_e, stall_e});
            end
            tick();
        end
        #1;
        testsRun++;
        if ({stall_f, stall_d, flush_e, stall_e, mul_busy} !== 5'b00000) begin
            testsFailed++;
            $display("[TB] FAIL b2b_accept: got %b want 00000",
                     {stall_f, stall_d, flush_e, stall_e, mul_busy});
        end
        tick();
        clearInputs();
        rs_d = 5'd10;
        #1;
        testsRun++;
        if ({stall_f, stall_d, flush_e, stall_e, mul_busy} !== 5'b11101) begin
            testsFailed++;
            $display("[TB] FAIL b2b_reload: got %b want 11101",
                     {stall_f, stall_d, flush_e, stall_e, mul_busy});
        end
        clearInputs();
        for (int i = 0; i < MUL_LAT; i++) tick();
    endtask

    task automatic test_reset_mid_busy();
        clearInputs();
        mul_issue_e = 1'b1; mul_dst_e = 5'd7;
        tick();
        clearInputs();
        rs_d = 5'd7;
        tick();
        testsRun++;
        if (mul_busy !== 1'b1 || stall_d !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_busy: got busy=%b stall_d=%b want 1 1", mul_busy, stall_d);
        end
        reset_n = 1'b0;
        issueCyc = -1000;
        #1;
        testsRun++;
        if ({stall_f, stall_d, flush_e, stall_e, mul_busy, mul_prod_v} !== 6'b000000) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got %b want 000000",
                     {stall_f, stall_d, flush_e, stall_e, mul_busy, mul_prod_v});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < MUL_LAT + 1; i++) begin
            #1;
            testsRun++;
            if ({stall_d, mul_busy, mul_prod_v} !== 3'b000) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_idle[%0d]: got %b want 000", i,
                         {stall_d, mul_busy, mul_prod_v});
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [11:0] expected;
        logic [11:0] observed;
        for (int n = 0; n < 600; n++) begin
            rs_d = RAW'($urandom_range(0, 7)); rt_d = RAW'($urandom_range(0, 7));
            rs_e = RAW'($urandom_range(0, 7)); rt_e = RAW'($urandom_range(0, 7));
            write_reg_e = RAW'($urandom_range(0, 7));
            write_reg_m = RAW'($urandom_range(0, 7));
            write_reg_w = RAW'($urandom_range(0, 7));
            reg_write_e = 1'($urandom); reg_write_m = 1'($urandom); reg_write_w = 1'($urandom);
            mem_to_reg_e = ($urandom_range(0, 3) == 0);
            mem_to_reg_m = ($urandom_range(0, 3) == 0);
            branch_d = ($urandom_range(0, 3) == 0);
            mul_issue_e = ($urandom_range(0, 2) == 0);
            mul_dst_e = RAW'($urandom_range(0, 7));
            #1;
            expected = modelOutputs(cyc);
            observed = {forward_ae, forward_be, forward_ad, forward_bd, stall_f, stall_d,
                        flush_e, stall_e, mul_busy, mul_prod_v};
            testsRun++;
            if (observed !== expected) begin
                testsFailed++;
                $display("[TB] FAIL random[%0d]: got %b want %b", n, observed, expected);
            end
            tick();
        end
        clearInputs();
        for (int i = 0; i < MUL_LAT; i++) tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_counters();
        clearInputs();
        reset_n = 1'b0;
        issueCyc = -1000;
        #1;
        testsRun++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        reset_n = 1'b1;
        mem_to_reg_e = 1'b1; write_reg_e = 5'd5; rt_d = 5'd5;
        for (int i = 0; i < 3; i++) tick();
        testsRun++;
        if (stall_cnt !== PERF_W'(3) || flush_cnt !== PERF_W'(3)) begin
            testsFailed++;
            $display("[TB] FAIL perf_count: got %0d/%0d want 3/3", stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 17; i++) tick();
        testsRun++;
        if (stall_cnt !== PERF_W'(15) || flush_cnt !== PERF_W'(15)) begin
            testsFailed++;
            $display("[TB] FAIL perf_saturate: got %0d/%0d want 15/15", stall_cnt, flush_cnt);
        end
        reset_n = 1'b0;
        #1;
        testsRun++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            testsFailed++;
            $display("[TB] FAIL perf_rereset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        reset_n = 1'b1;
        clearInputs();
        tick();
    endtask
`endif

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_forwarding();
        test_load_stall();
        test_mul_stall();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
